// File: rtl/relay_frame_detector.sv
// Serial relay frame detector: samples rx_bit once per divider period, matches start/end framing
// per role and drives the ISO14443-A modulation type. Optional frame watchdog: RELAY_FRAME_TIMEOUT_EN.
module relay_frame_detector #(
  parameter int             DIV_W          = 4,
  parameter int             SAMPLE_PHASE   = 8,
  parameter int             BUF_W          = 32,
  parameter int             TAP            = 15,
  parameter logic [7:0]     START_R        = 8'hc0,
  parameter logic [15:0]    END_R1         = 16'h0000,
  parameter logic [15:0]    END_R2         = 16'hc000,
  parameter logic [7:0]     START_T        = 8'hf0,
  parameter logic [7:0]     END_T          = 8'h00,
  parameter int             CNT_W          = 8,
  parameter int             MAX_FRAME_BITS = 4096
) (
  input  logic             ck_1356meg,
  input  logic             rst,
  input  logic [2:0]       role,
  input  logic             rx_bit,
  output logic [2:0]       mod_type,
  output logic             data_tap,
  output logic             sample_stb,
  output logic             in_frame,
  output logic             frame_done,
  output logic [CNT_W-1:0] frame_bytes
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LISTEN = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  logic             is_rdr, is_tag, is_relay;
  logic [1:0]       kind_q;
  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [BUF_W-1:0] buf_q, buf_d, shift_buf;
  logic [2:0]       bitc_q, bitc_d, bitc_inc;
  logic [CNT_W-1:0] bytes_q, bytes_d;
  logic             tap_q, stb_q, done_q, in_frame_q;
  logic             sample, done, start_hit, end_hit;

  assign is_rdr    = (role == 3'b101);
  assign is_tag    = (role == 3'b110);
  assign is_relay  = is_rdr | is_tag;
  assign shift_buf = {buf_q[BUF_W-2:0], rx_bit};
  assign bitc_inc  = bitc_q + 3'd1;

  // Match tests look at the buffer as it will be after this sample's shift.
  assign start_hit = is_rdr ? (shift_buf[23:0] == {16'h0, START_R})
                            : (shift_buf[23:0] == {16'h0, START_T});
  assign end_hit   = (state_q == ST_ACTIVE) && !start_hit && (bitc_inc == 3'd0) &&
                     (is_rdr ? ((shift_buf[31:0] == {END_R1, 16'h0}) ||
                                (shift_buf[31:0] == {END_R2, 16'h0}))
                             : (shift_buf[23:0] == {END_T, 16'h0}));

`ifdef RELAY_FRAME_TIMEOUT_EN
  localparam int WD_W = $clog2(MAX_FRAME_BITS + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    bitc_d  = bitc_q;
    bytes_d = bytes_q;
    sample  = 1'b0;
    done    = 1'b0;
`ifdef RELAY_FRAME_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    if ({is_rdr, is_tag} != kind_q || !is_relay) begin
      state_d = is_relay ? ST_LISTEN : ST_IDLE;
      buf_d   = '0;
      bitc_d  = '0;
    end else if (div_q == DIV_W'(SAMPLE_PHASE)) begin
      sample = 1'b1;
      buf_d  = shift_buf;
      bitc_d = bitc_inc;
      if (start_hit) begin
        state_d = ST_ACTIVE;
        bitc_d  = '0;
        bytes_d = '0;
`ifdef RELAY_FRAME_TIMEOUT_EN
        wd_d    = '0;
`endif
      end else if (state_q == ST_ACTIVE) begin
        if (bitc_inc == 3'd0 && bytes_q != {CNT_W{1'b1}})
          bytes_d = bytes_q + 1'b1;
`ifdef RELAY_FRAME_TIMEOUT_EN
        wd_d = wd_q + 1'b1;
`endif
        if (end_hit) begin
          state_d = ST_LISTEN;
          done    = 1'b1;
        end
`ifdef RELAY_FRAME_TIMEOUT_EN
        else if (wd_d == WD_W'(MAX_FRAME_BITS)) begin
          state_d = ST_LISTEN;
          done    = 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge ck_1356meg) begin
    if (rst) begin
      state_q    <= is_relay ? ST_LISTEN : ST_IDLE;
      kind_q     <= {is_rdr, is_tag};
      div_q      <= '0;
      buf_q      <= '0;
      bitc_q     <= '0;
      bytes_q    <= '0;
      tap_q      <= 1'b0;
      stb_q      <= 1'b0;
      done_q     <= 1'b0;
      in_frame_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      kind_q     <= {is_rdr, is_tag};
      div_q      <= div_q + 1'b1;
      buf_q      <= buf_d;
      bitc_q     <= bitc_d;
      bytes_q    <= bytes_d;
      tap_q      <= buf_d[TAP];
      stb_q      <= sample;
      done_q     <= done;
      in_frame_q <= (state_d == ST_ACTIVE);
    end
  end

`ifdef RELAY_FRAME_TIMEOUT_EN
  always_ff @(posedge ck_1356meg) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`endif

  always_comb begin
    case (state_q)
      ST_LISTEN: mod_type = is_rdr ? 3'b011 : 3'b001;
      ST_ACTIVE: mod_type = is_rdr ? 3'b100 : 3'b010;
      default:   mod_type = role;
    endcase
  end

  assign data_tap    = tap_q;
  assign sample_stb  = stb_q;
  assign frame_done  = done_q;
  assign in_frame    = in_frame_q;
  assign frame_bytes = bytes_q;

endmodule

// File: tb/tb_relay_frame_detector.sv
// Directed bench for relay_frame_detector: vector table of byte/bit groups plus hand-written
// sequences for first-sample timing, role switching, watchdog and mid-frame reset.
module tb_relay_frame_detector;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] role = 3'b000;
  logic       rx_bit = 1'b0;
  logic [2:0] mod_type;
  logic       data_tap, sample_stb, in_frame, frame_done;
  logic [7:0] frame_bytes;

  int n_vec = 0;
  int n_bad = 0;
  int done_cnt = 0;

  relay_frame_detector #(.MAX_FRAME_BITS(64)) dut (
    .ck_1356meg (clk),
    .rst        (rst),
    .role       (role),
    .rx_bit     (rx_bit),
    .mod_type   (mod_type),
    .data_tap   (data_tap),
    .sample_stb (sample_stb),
    .in_frame   (in_frame),
    .frame_done (frame_done),
    .frame_bytes(frame_bytes)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         do_rst;
    logic [2:0] role;
    int         nbits;
    logic [7:0] dat;
    logic [2:0] exp_mod;
    logic       exp_inf;
    int         exp_bytes;
    int         exp_done;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset(input logic [2:0] r);
    @(negedge clk);
    role = r;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Present one bit and wait for the sample that takes it; frame_done pulses are tallied.
  task automatic send_bit(input logic b);
    int  n;
    bit  got;
    rx_bit = b;
    n = 0;
    got = 0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (sample_stb) got = 1;
      if (frame_done) done_cnt++;
    end
    if (!got) check("sample_timeout", 0, 1);
  endtask

  task automatic send_bits(input int nb, input logic [7:0] d);
    for (int i = nb - 1; i >= 0; i--) send_bit(d[i]);
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b1, 3'b101, 8, 8'h00, 3'b011, 1'b0, 0, 0};
    vecs[1]  = '{1'b0, 3'b101, 8, 8'h00, 3'b011, 1'b0, 0, 0};
    vecs[2]  = '{1'b0, 3'b101, 8, 8'hc0, 3'b100, 1'b1, 0, 0};
    vecs[3]  = '{1'b0, 3'b101, 8, 8'ha5, 3'b100, 1'b1, 1, 0};
    vecs[4]  = '{1'b0, 3'b101, 8, 8'h3c, 3'b100, 1'b1, 2, 0};
    vecs[5]  = '{1'b0, 3'b101, 8, 8'hc0, 3'b100, 1'b1, 3, 0};
    vecs[6]  = '{1'b0, 3'b101, 8, 8'h00, 3'b100, 1'b1, 4, 0};
    vecs[7]  = '{1'b0, 3'b101, 8, 8'h00, 3'b100, 1'b1, 5, 0};
    vecs[8]  = '{1'b0, 3'b101, 8, 8'h00, 3'b011, 1'b0, 6, 1};
    vecs[9]  = '{1'b1, 3'b110, 8, 8'h00, 3'b001, 1'b0, 0, 0};
    vecs[10] = '{1'b0, 3'b110, 8, 8'h00, 3'b001, 1'b0, 0, 0};
    vecs[11] = '{1'b0, 3'b110, 8, 8'hf0, 3'b010, 1'b1, 0, 0};
    vecs[12] = '{1'b0, 3'b110, 3, 8'h07, 3'b010, 1'b1, 0, 0};
    vecs[13] = '{1'b0, 3'b110, 8, 8'h00, 3'b010, 1'b1, 1, 0};
    vecs[14] = '{1'b0, 3'b110, 8, 8'h00, 3'b010, 1'b1, 2, 0};
    vecs[15] = '{1'b0, 3'b110, 8, 8'h00, 3'b010, 1'b1, 3, 0};
    vecs[16] = '{1'b0, 3'b110, 8, 8'hf0, 3'b010, 1'b1, 0, 0};
    vecs[17] = '{1'b0, 3'b110, 8, 8'h00, 3'b010, 1'b1, 1, 0};
    vecs[18] = '{1'b0, 3'b110, 8, 8'h00, 3'b010, 1'b1, 2, 0};
    vecs[19] = '{1'b0, 3'b110, 8, 8'h00, 3'b001, 1'b0, 3, 1};

    // Reset values, and first sample arriving on clock SAMPLE_PHASE+1.
    @(negedge clk);
    role = 3'b101;
    rst  = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mod_type", mod_type, 3'b011);
    check("rst_in_frame", in_frame, 0);
    check("rst_frame_bytes", frame_bytes, 0);
    check("rst_sample_stb", sample_stb, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_data_tap", data_tap, 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!sample_stb && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("first_sample_clock", n, 9);

    do_reset(3'b000);
    check("rst_idle_mod_type", mod_type, 3'b000);

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].do_rst) do_reset(vecs[i].role);
      else role = vecs[i].role;
      done_cnt = 0;
      send_bits(vecs[i].nbits, vecs[i].dat);
      check($sformatf("v%0d_mod_type", i), mod_type, vecs[i].exp_mod);
      check($sformatf("v%0d_in_frame", i), in_frame, vecs[i].exp_inf);
      check($sformatf("v%0d_frame_bytes", i), frame_bytes, vecs[i].exp_bytes);
      check($sformatf("v%0d_frame_done_cnt", i), done_cnt, vecs[i].exp_done);
    end

    // Role switching clears the buffer and walks LISTEN -> IDLE -> LISTEN.
    do_reset(3'b101);
    send_bits(8, 8'hff);
    send_bits(8, 8'hff);
    check("sw_tap_loaded", data_tap, 1);
    @(negedge clk);
    role = 3'b110;
    @(posedge clk);
    #1;
    check("sw_tag_mod_type", mod_type, 3'b001);
    check("sw_tag_tap_cleared", data_tap, 0);
    @(negedge clk);
    role = 3'b000;
    @(posedge clk);
    #1;
    check("sw_idle_mod_type", mod_type, 3'b000);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (sample_stb) n++;
    end
    check("sw_idle_no_samples", n, 0);
    @(negedge clk);
    role = 3'b101;
    #1;
    check("sw_idle_follows_role", mod_type, 3'b101);
    @(posedge clk);
    #1;
    check("sw_rdr_mod_type", mod_type, 3'b011);
    send_bits(8, 8'hc0);
    check("sw_start_after_clear", mod_type, 3'b100);

    // Watchdog: 64 samples of ones after a start.
    do_reset(3'b101);
    send_bits(8, 8'hc0);
    check("wd_in_frame", in_frame, 1);
    done_cnt = 0;
    for (int i = 0; i < 63; i++) send_bit(1'b1);
    check("wd_63_in_frame", in_frame, 1);
    check("wd_63_done_cnt", done_cnt, 0);
    send_bit(1'b1);
    check("wd_64_frame_bytes", frame_bytes, 8);
`ifdef RELAY_FRAME_TIMEOUT_EN
    check("wd_64_done_cnt", done_cnt, 1);
    check("wd_64_mod_type", mod_type, 3'b011);
    check("wd_64_in_frame", in_frame, 0);
`else
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    check("wd_74_done_cnt", done_cnt, 0);
    check("wd_74_mod_type", mod_type, 3'b100);
    check("wd_74_in_frame", in_frame, 1);
`endif

    // Reset mid-frame aborts without a frame_done pulse.
    do_reset(3'b101);
    send_bits(8, 8'hc0);
    send_bits(8, 8'ha5);
    check("mr_tap_before", data_tap, 1);
    check("mr_bytes_before", frame_bytes, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mr_mod_type", mod_type, 3'b011);
    check("mr_in_frame", in_frame, 0);
    check("mr_frame_bytes", frame_bytes, 0);
    check("mr_data_tap", data_tap, 0);
    check("mr_sample_stb", sample_stb, 0);
    check("mr_frame_done", frame_done, 0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) n++;
    end
    check("mr_no_done_after", n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
